// File: rtl/tx_arbiter.sv
// tx_arbiter
// Round-robin arbiter that shares one transmitter among N_REQ requesters.
// A granted requester's address is latched and presented to the transmitter
// with a single start pulse. The arbiter then waits for ready, or aborts
// after TIMEOUT wait cycles, and finally returns a one-cycle ack pulse.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   req          level request per requester, held until ack
//   req_addr     packed addresses, slice i belongs to requester i
//   ack          one-cycle completion pulse to the granted requester
//   timeout      one-cycle pulse alongside ack when the transfer aborted
//   start        one-cycle start pulse to the transmitter
//   address_bus  latched address while busy, 0 when idle
//   ready        transmitter completion, sampled only in WAIT
//   busy         high whenever the FSM is not in IDLE
//   grant_id     index of the current or last granted requester
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no transfer; arbitrate among req on every edge
// ISSUE | start pulse, address_bus driven, wait counter cleared
// WAIT  | wait for ready, or abort once the counter hits TIMEOUT-1
// DONE  | ack (plus timeout if aborted), advance rr_ptr
module tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 64,
    localparam int GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]            ack,
    output logic                        timeout,
    output logic                        start,
    output logic [ADDR_WIDTH-1:0]       address_bus,
    input  logic                        ready,
    output logic                        busy,
    output logic [GW-1:0]               grant_id
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int GW1 = GW + 1;

    logic [1:0]            state;
    logic [GW-1:0]         rr_ptr;
    logic [CW-1:0]         cnt;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  pick_valid;
    logic [GW-1:0]         pick_id;
    logic [GW1-1:0]        idx;
    logic [GW-1:0]         rr_next;

    // Scan from the highest offset down so the requester closest to rr_ptr
    // is the last (and therefore winning) assignment.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + GW1'(k);
            if (idx >= GW1'(N_REQ)) begin
                idx = idx - GW1'(N_REQ);
            end
            if (req[idx[GW-1:0]]) begin
                pick_valid = 1'b1;
                pick_id    = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        if (grant_id == GW'(N_REQ - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = grant_id + GW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            grant_id <= '0;
            addr_q   <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            abort    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_id;
                        addr_q   <= req_addr[int'(pick_id)*ADDR_WIDTH +: ADDR_WIDTH];
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    abort <= 1'b0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // ready wins over a coincident terminal count
                    if (ready) begin
                        abort <= 1'b0;
                        state <= S_DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        abort <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    rr_ptr <= rr_next;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state only, so reset clears them
    // immediately through the asynchronous state reset.
    assign busy        = (state != S_IDLE);
    assign start       = (state == S_ISSUE);
    assign timeout     = (state == S_DONE) && abort;
    assign address_bus = (state == S_IDLE) ? '0 : addr_q;

    always_comb begin
        ack = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ack[i] = (state == S_DONE) && (grant_id == GW'(i));
        end
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_REQ, 4, number of requesters sharing the transmitter (2..8).
- ADDR_WIDTH, 8, width of address_bus.
- TIMEOUT, 64, maximum WAIT cycles before abort (>=2).

REQ-002 Ports (name, direction, width, meaning), one per line:
- clock, in, 1, single clock; all logic on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- req, in, N_REQ, level request per requester; held until ack.
- req_addr, in, N_REQ*ADDR_WIDTH, packed addresses; slice i belongs to requester i.
- ack, out, N_REQ, one-cycle completion pulse to the granted requester.
- timeout, out, 1, one-cycle pulse coincident with ack when the transfer aborted.
- start, out, 1, one-cycle start pulse to the transmitter.
- address_bus, out, ADDR_WIDTH, address to the transmitter.
- ready, in, 1, transmitter completion indication.
- busy, out, 1, high in every state except IDLE.
- grant_id, out, clog2(N_REQ), index of the current or last granted requester.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE, one state per cycle except WAIT.
REQ-004 In IDLE, when any req bit is high, the block SHALL select a requester round-robin:
- Search starts at rr_ptr, incrementing mod N_REQ.
- The block latches grant_id and req_addr[grant_id] into an address register.
- The FSM moves to ISSUE on the next edge.
REQ-005 With no req high, the FSM SHALL remain in IDLE.
REQ-006 In ISSUE, start SHALL be 1 and address_bus SHALL equal the latched address; the FSM then moves to WAIT unconditionally.
REQ-007 start SHALL be 0 in every state other than ISSUE; it is never high for two consecutive cycles.
REQ-008 address_bus SHALL hold the latched address from ISSUE through DONE and SHALL be 0 in IDLE.
REQ-009 ready SHALL be sampled only in WAIT; ready high during IDLE, ISSUE or DONE is ignored.
REQ-010 In WAIT, a cycle counter cleared on WAIT entry SHALL increment each cycle. The exit rules are:
- ready=1 moves to DONE with a normal completion.
- Counter reaching TIMEOUT-1 with ready=0 moves to DONE with the abort flag set.
REQ-011 If ready=1 in the same cycle the counter reaches TIMEOUT-1, the result SHALL be a normal completion with no abort.
REQ-012 In DONE, the block SHALL perform all of the following:
- Assert ack[grant_id]=1 for exactly one cycle.
- Assert timeout=1 if and only if the abort flag is set.
- Set rr_ptr to (grant_id+1) mod N_REQ.
- Return to IDLE.
REQ-013 Minimum transaction timing is fixed as follows:
- req is seen in IDLE at cycle 0.
- start is high at cycle 1.
- ready can be sampled at cycle 2 at the earliest.
- ack is high at cycle 3.
- A new grant (IDLE) is possible at cycle 4.
REQ-014 Deasserting req[grant_id] after grant SHALL NOT cancel the transaction; ack still pulses.
REQ-015 Changes on req_addr after latching SHALL NOT affect address_bus.
REQ-016 At most one ack bit SHALL be high in any cycle.

Reset
REQ-017 While reset=0, the block SHALL immediately, without waiting for a clock edge, force:
- state to IDLE; start=0, ack=0, timeout=0, busy=0.
- address_bus=0, grant_id=0.
- rr_ptr=0, counter=0, abort flag=0.
REQ-018 Reset asserted in any state, including mid-WAIT, SHALL abandon the transaction with no ack.
REQ-019 After reset deassertion, arbitration SHALL begin from requester 0 on the first rising edge.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Single requester: req=0001, addr0=8'h3C, ready pulsed in the 3rd WAIT cycle -> start=1 with address_bus=8'h3C at cycle 1; ack=0001 one cycle after ready; timeout=0.
- Round-robin: req=1111 held, ready returned in the first WAIT cycle every time -> grant order 0,1,2,3,0; ack pulses every 4 cycles.
- Timeout: req=0100, ready tied 0, TIMEOUT=64 -> after 64 WAIT cycles, ack=0100 with timeout=1; rr_ptr=3 afterwards.
- Boundary timing: ready=1 during ISSUE only -> ignored, and the transfer later times out; ready=1 in the final WAIT cycle -> ack with timeout=0.
- Reset mid-transaction: reset=0 in the 5th WAIT cycle -> all outputs 0 asynchronously; no ack; after release with req=1010, requester 1 is granted first.
- Withdrawn request: req[2] dropped one cycle after grant -> ack[2] still pulses; address_bus stable throughout.
